// File: rtl/wave_chk_pkg.sv
// wave_chk_pkg
// Shared types and helpers for the waveform checker.
//   state_t : checker FSM states (IDLE=0, SYNC=1, TRACK=2, FAIL=3)
//   STAT_W  : width of every statistics counter
//   has_x / has_z / is_known : four-state inspection of the low 'w' bits
//   of a value zero-extended to 64 bits, so one function serves any width.
package wave_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam int STAT_W = 16;

  function automatic logic has_x(input logic [63:0] v, input int w);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < w && v[i] === 1'bx) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic has_z(input logic [63:0] v, input int w);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < w && v[i] === 1'bz) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic is_known(input logic [63:0] v, input int w);
    return !(has_x(v, w) || has_z(v, w));
  endfunction

endpackage

// File: rtl/wave_checker_classify.sv
// wave_classify
// Combinational classifier of one four-state data sample.
//   data     : sample to classify (DATA_W bits)
//   is_x     : at least one bit is X
//   is_z     : at least one bit is Z and no bit is X
//   is_clean : every bit is 0 or 1
// Exactly one output is high; X takes priority over Z.
module wave_classify
  import wave_chk_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              is_x,
  output logic              is_z,
  output logic              is_clean
);

  always_comb begin
    is_x     = has_x(64'(data), DATA_W);
    is_z     = !is_x && has_z(64'(data), DATA_W);
    is_clean = !is_x && !is_z;
  end

endmodule

// File: rtl/wave_checker.sv
// wave_checker
// Consumes the waveform generator's up/down counter pair and data byte.
// Checks that each counter steps by exactly +1 / -1 per sample (modulo
// 2^CNT_W), classifies data as clean / X / Z, and keeps saturating stats.
//   clk, reset     : clock, synchronous active-low reset
//   sample_en      : take one sample this cycle
//   clr_stats      : clear statistics and return FSM to IDLE (wins over sample)
//   cnt_up/cnt_down: counters under check
//   data           : four-state data to classify
//   state          : IDLE/SYNC/TRACK/FAIL
//   up_err_cnt, down_err_cnt, x_cnt, z_cnt, clean_cnt : saturating stats
//   err_pulse      : one-cycle strobe for a sample with any step error
//   fail           : high while in FAIL
module wave_checker
  import wave_chk_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DATA_W    = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              clr_stats,
  input  logic [CNT_W-1:0]  cnt_up,
  input  logic [CNT_W-1:0]  cnt_down,
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] up_err_cnt,
  output logic [STAT_W-1:0] down_err_cnt,
  output logic [STAT_W-1:0] x_cnt,
  output logic [STAT_W-1:0] z_cnt,
  output logic [STAT_W-1:0] clean_cnt,
  output logic              err_pulse,
  output logic              fail
);

  state_t            cur_state, next_state;
  logic [CNT_W-1:0]  exp_up, exp_dn;
  logic [31:0]       tally, tally_next;
  logic              up_known, dn_known;
  logic              up_mis, dn_mis, load_up, load_dn, err_next;
  logic              is_x, is_z, is_clean;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  wave_classify #(.DATA_W(DATA_W)) u_classify (
    .data     (data),
    .is_x     (is_x),
    .is_z     (is_z),
    .is_clean (is_clean)
  );

  assign up_known = is_known(64'(cnt_up), CNT_W);
  assign dn_known = is_known(64'(cnt_down), CNT_W);

  // Next-state and step-check decisions. The unsaturated tally decides FAIL
  // so saturation of the visible error counters can never mask the limit.
  always_comb begin
    next_state = cur_state;
    up_mis     = 1'b0;
    dn_mis     = 1'b0;
    load_up    = 1'b0;
    load_dn    = 1'b0;
    err_next   = 1'b0;
    tally_next = tally;
    if (clr_stats) begin
      next_state = ST_IDLE;
    end else if (sample_en) begin
      case (cur_state)
        ST_IDLE, ST_SYNC: begin
          if (up_known && dn_known) begin
            load_up    = 1'b1;
            load_dn    = 1'b1;
            next_state = ST_TRACK;
          end else begin
            next_state = ST_SYNC;
          end
        end
        ST_TRACK: begin
          up_mis     = !up_known || (cnt_up != exp_up);
          dn_mis     = !dn_known || (cnt_down != exp_dn);
          load_up    = up_known;
          load_dn    = dn_known;
          err_next   = up_mis || dn_mis;
          tally_next = tally + 32'(up_mis) + 32'(dn_mis);
          if (tally_next >= 32'(ERR_LIMIT)) next_state = ST_FAIL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cur_state <= ST_IDLE;
    else        cur_state <= next_state;
  end

  // Expectations, tally and statistics. Gaps leave everything untouched;
  // expectations re-sync to the observation so one glitch costs one error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_up       <= '0;
      exp_dn       <= '0;
      tally        <= '0;
      up_err_cnt   <= '0;
      down_err_cnt <= '0;
      x_cnt        <= '0;
      z_cnt        <= '0;
      clean_cnt    <= '0;
      err_pulse    <= 1'b0;
    end else if (clr_stats) begin
      tally        <= '0;
      up_err_cnt   <= '0;
      down_err_cnt <= '0;
      x_cnt        <= '0;
      z_cnt        <= '0;
      clean_cnt    <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= err_next;
      if (sample_en) begin
        tally <= tally_next;
        if (load_up) exp_up <= cnt_up + CNT_W'(1);
        if (load_dn) exp_dn <= cnt_down - CNT_W'(1);
        if (up_mis) up_err_cnt <= sat_inc(up_err_cnt);
        if (dn_mis) down_err_cnt <= sat_inc(down_err_cnt);
        if (is_x) x_cnt <= sat_inc(x_cnt);
        if (is_z) z_cnt <= sat_inc(z_cnt);
        if (is_clean) clean_cnt <= sat_inc(clean_cnt);
      end
    end
  end

  assign state = cur_state;
  assign fail  = (cur_state == ST_FAIL);

endmodule
